// File: rtl/fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_prefetch_queue
// Purpose  : Instruction prefetcher. Issues word-aligned fetch requests under
//            a credit limit and buffers returned instructions with their PCs
//            in a FIFO for the decoder. Redirects flush the queue and discard
//            stale responses that are still in flight.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_prefetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4
);

  localparam int unsigned       c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned       c_cnt_w = c_ptr_w + 1;
  localparam int unsigned       c_sum_w = c_cnt_w + 2;
  localparam logic [c_sum_w-1:0] c_depth = c_sum_w'(DEPTH);
  localparam logic [XLEN-1:0]   c_four  = XLEN'(4);
  localparam logic [XLEN-1:0]   c_align = ~(XLEN'(3));
  localparam logic [31:0]       c_nop   = 32'h0000_0013;

  // Fetch address and decoder-facing queue storage
  logic [XLEN-1:0]    r_fetch_pc;
  logic [31:0]        r_q_instr [DEPTH];
  logic [XLEN-1:0]    r_q_pc    [DEPTH];
  logic [c_ptr_w-1:0] r_q_head;
  logic [c_ptr_w-1:0] r_q_tail;
  logic [c_cnt_w-1:0] r_q_count;

  // PCs of live requests awaiting their response, oldest at the head
  logic [XLEN-1:0]    r_if_pc   [DEPTH];
  logic [c_ptr_w-1:0] r_if_head;
  logic [c_ptr_w-1:0] r_if_tail;
  logic [c_cnt_w-1:0] r_if_count;

  // Responses still owed for requests made before the last redirect
  logic [c_cnt_w-1:0] r_drop_cnt;

  logic [c_sum_w-1:0] w_credit_used;
  logic               w_req_fire;
  logic               w_rsp_answered;
  logic               w_rsp_stale;
  logic               w_rsp_accept;
  logic               w_pop;
  logic [XLEN-1:0]    w_head_pc;

  // Stale responses always precede live ones, so drop_cnt alone classifies a response
  assign w_credit_used  = c_sum_w'(r_q_count) + c_sum_w'(r_if_count) + c_sum_w'(r_drop_cnt);
  assign imem_req_valid = !rst && !redirect_valid && (w_credit_used < c_depth);
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;
  assign w_rsp_answered = imem_rsp_valid && ((r_drop_cnt != '0) || (r_if_count != '0));
  assign w_rsp_stale    = imem_rsp_valid && (r_drop_cnt != '0);
  assign w_rsp_accept   = imem_rsp_valid && (r_drop_cnt == '0) && (r_if_count != '0)
                          && !rst && !redirect_valid;

  assign out_valid      = !rst && !redirect_valid && (r_q_count != '0);
  assign w_pop          = out_valid && out_ready;
  assign w_head_pc      = rst ? RESET_PC : r_q_pc[r_q_head];
  assign out_pc         = w_head_pc;
  assign out_pc_plus4   = w_head_pc + c_four;
  assign out_instr      = rst ? c_nop : r_q_instr[r_q_head];

  // Control state: fetch PC, FIFO pointers, occupancy and discard counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_q_head   <= '0;
      r_q_tail   <= '0;
      r_q_count  <= '0;
      r_if_head  <= '0;
      r_if_tail  <= '0;
      r_if_count <= '0;
      r_drop_cnt <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc & c_align;
      r_q_head   <= '0;
      r_q_tail   <= '0;
      r_q_count  <= '0;
      r_if_head  <= '0;
      r_if_tail  <= '0;
      r_if_count <= '0;
      // Everything still owed becomes stale; a response arriving now is itself discarded
      r_drop_cnt <= r_drop_cnt + r_if_count - c_cnt_w'(w_rsp_answered);
    end else begin
      if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + c_four;
        r_if_tail  <= r_if_tail + c_ptr_w'(1);
      end
      if (w_rsp_accept) begin
        r_if_head <= r_if_head + c_ptr_w'(1);
        r_q_tail  <= r_q_tail + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_q_head <= r_q_head + c_ptr_w'(1);
      end
      if (w_rsp_stale) begin
        r_drop_cnt <= r_drop_cnt - c_cnt_w'(1);
      end
      r_if_count <= r_if_count + c_cnt_w'(w_req_fire) - c_cnt_w'(w_rsp_accept);
      r_q_count  <= r_q_count + c_cnt_w'(w_rsp_accept) - c_cnt_w'(w_pop);
    end
  end

  // Payload storage; validity is tracked entirely by the pointers above
  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_if_pc[r_if_tail] <= r_fetch_pc;
    end
    if (w_rsp_accept) begin
      r_q_instr[r_q_tail] <= imem_rsp_data;
      r_q_pc[r_q_tail]    <= r_if_pc[r_if_head];
    end
  end

endmodule
`default_nettype wire
